// File: rtl/tb_irq_sched.sv
// -----------------------------------------------------------------------------
// tb_irq_sched
//
// Interrupt stimulus scheduler for the core testbench. It produces seeded,
// pseudo-random, timed interrupt events on the timer, software, PLIC and debug
// level lines, and on the NMI pulse line. A level interrupt is held until the
// core acknowledges it, or until MAX_HOLD cycles have passed. A hold that ends
// without an acknowledge sets a sticky timeout flag.
//
// Parameters
//   SEED      LFSR reset value (0 is replaced by 1)
//   MIN_GAP   minimum idle cycles between events (>=1)
//   GAP_MASK  mask applied to the random gap addend
//   MAX_HOLD  maximum cycles a level interrupt waits for an ack (>=1)
//   NMI_PULSE NMI pulse width in cycles (>=1)
//
// Ports
//   tb_clk, tb_rst    clock, synchronous active-high reset
//   cfg_ena           scheduler enable
//   cfg_wfi           gap counts only while core_wfi is high
//   src_mask[4:0]     per-source enable {dbg,nmi,plic,sft,tmr}
//   core_wfi          core is sleeping in WFI
//   irq_ack[3:0]      level acknowledge {dbg,plic,sft,tmr}
//   tb_stop           test finishing; forces IDLE
//   tb_*_irq, tb_nmi  registered interrupt outputs (at most one high)
//   fire_cnt[15:0]    saturating count of fired events
//   timeout_err       sticky: a level interrupt timed out
// -----------------------------------------------------------------------------
module tb_irq_sched #(
  parameter logic [31:0] SEED      = 32'h1,
  parameter int unsigned MIN_GAP   = 16,
  parameter logic [7:0]  GAP_MASK  = 8'hFF,
  parameter int unsigned MAX_HOLD  = 1024,
  parameter int unsigned NMI_PULSE = 4
) (
  input  logic        tb_clk,
  input  logic        tb_rst,
  input  logic        cfg_ena,
  input  logic        cfg_wfi,
  input  logic [4:0]  src_mask,
  input  logic        core_wfi,
  input  logic [3:0]  irq_ack,
  input  logic        tb_stop,
  output logic        tb_tmr_irq,
  output logic        tb_sft_irq,
  output logic        tb_plic_irq,
  output logic        tb_dbg_irq,
  output logic        tb_nmi,
  output logic [15:0] fire_cnt,
  output logic        timeout_err
);

  // Wide enough for MIN_GAP + 255 so the reload sum never overflows.
  localparam int GAP_W   = $clog2(MIN_GAP + 256);
  localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
  localparam int PULSE_W = $clog2(NMI_PULSE + 1);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_PULSE = 2'd3;

  // Level source index: 0 tmr, 1 sft, 2 plic, 3 dbg (matches irq_ack order).
  logic [1:0]         state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [1:0]         src_q, src_d;
  logic [3:0]         lvl_q, lvl_d;
  logic               nmi_q, nmi_d;
  logic [15:0]        fire_cnt_q, fire_cnt_d;
  logic               timeout_q, timeout_d;

  logic [GAP_W-1:0]   new_gap;
  logic               sel_nmi;
  logic [1:0]         sel_src;
  logic [2:0]         sel_bit;
  logic               abort;
  logic               gap_tick;

  // Fresh gap length, drawn from the LFSR value of the cycle that loads it.
  assign new_gap  = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[15:8] & GAP_MASK);
  assign abort    = !cfg_ena || tb_stop;
  assign gap_tick = !cfg_wfi || core_wfi;

  // Source selection from the low LFSR bits; sel_bit indexes src_mask.
  always_comb begin
    sel_nmi = 1'b0;
    sel_src = 2'd0;
    sel_bit = 3'd0;
    case (lfsr_q[2:0])
      3'd0, 3'd1: begin sel_src = 2'd0; sel_bit = 3'd0; end
      3'd2, 3'd3: begin sel_src = 2'd1; sel_bit = 3'd1; end
      3'd4, 3'd5: begin sel_src = 2'd2; sel_bit = 3'd2; end
      3'd6:       begin sel_nmi = 1'b1; sel_bit = 3'd3; end
      default:    begin sel_src = 2'd3; sel_bit = 3'd4; end
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal is defaulted first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    gap_cnt_d   = gap_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    src_d       = src_q;
    lvl_d       = 4'b0000;
    nmi_d       = 1'b0;
    fire_cnt_d  = fire_cnt_q;
    timeout_d   = timeout_q;

    if (abort) begin
      // Abort beats everything, including an ack arriving in the same cycle.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_GAP;
          gap_cnt_d = new_gap;
        end

        S_GAP: begin
          if (gap_tick) begin
            if (gap_cnt_q <= GAP_W'(1)) begin
              if (src_mask[sel_bit]) begin
                if (fire_cnt_q != 16'hFFFF) fire_cnt_d = fire_cnt_q + 16'd1;
                if (sel_nmi) begin
                  state_d     = S_PULSE;
                  pulse_cnt_d = PULSE_W'(1);
                  nmi_d       = 1'b1;
                end else begin
                  state_d    = S_HOLD;
                  hold_cnt_d = HOLD_W'(1);
                  src_d      = sel_src;
                  lvl_d      = 4'b0001 << sel_src;
                end
              end else begin
                // Masked pick: draw a new gap and try again.
                gap_cnt_d = new_gap;
              end
            end else begin
              gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
          end
        end

        S_HOLD: begin
          // hold_cnt_q is the number of cycles the output has already been high.
          if (irq_ack[src_q]) begin
            state_d   = S_GAP;
            gap_cnt_d = new_gap;
          end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
            state_d   = S_GAP;
            gap_cnt_d = new_gap;
            timeout_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            lvl_d      = 4'b0001 << src_q;
          end
        end

        default: begin // S_PULSE
          if (pulse_cnt_q == PULSE_W'(NMI_PULSE)) begin
            state_d   = S_GAP;
            gap_cnt_d = new_gap;
          end else begin
            pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
            nmi_d       = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_INIT;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      src_q       <= 2'd0;
      lvl_q       <= 4'b0000;
      nmi_q       <= 1'b0;
      fire_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      src_q       <= src_d;
      lvl_q       <= lvl_d;
      nmi_q       <= nmi_d;
      fire_cnt_q  <= fire_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tb_tmr_irq  = lvl_q[0];
  assign tb_sft_irq  = lvl_q[1];
  assign tb_plic_irq = lvl_q[2];
  assign tb_dbg_irq  = lvl_q[3];
  assign tb_nmi      = nmi_q;
  assign fire_cnt    = fire_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/tb_irq_sched.md
# tb_irq_sched

Testbench interrupt stimulus scheduler that produces the timer, software, PLIC, NMI and debug interrupt waveforms driven into the core under test. It sits directly upstream of the testbench interrupt-generation stage. It turns the FORCE_IRQ / WFI_FORCE_IRQ plusarg intent into timed, pseudo-random, acknowledge-terminated interrupt events. It is reproducible from a seed and self-checks for interrupts the core never services.

## Interface
- SEED, 32'h1: LFSR reset value; a value of 0 is replaced by 32'h1.
- MIN_GAP, 16: minimum idle cycles between events; must be ≥1.
- GAP_MASK, 8'hFF: mask applied to the random gap addend.
- MAX_HOLD, 1024: maximum cycles a level interrupt is held waiting for ack; must be ≥1.
- NMI_PULSE, 4: NMI pulse width in cycles; must be ≥1.
- tb_clk  in  1  clock; single clock domain.
- tb_rst  in  1  synchronous, active-high reset.
- cfg_ena  in  1  scheduler enable (FORCE_IRQ ≠ 0).
- cfg_wfi  in  1  WFI mode (WFI_FORCE_IRQ ≠ 0).
- src_mask  in  5  per-source enable, bit order {dbg,nmi,plic,sft,tmr}.
- core_wfi  in  1  core is sleeping in WFI.
- irq_ack  in  4  level-source acknowledge, bit order {dbg,plic,sft,tmr}.
- tb_stop  in  1  test finishing; forces IDLE.
- tb_tmr_irq, tb_sft_irq, tb_plic_irq, tb_dbg_irq  out  1 each  level interrupts.
- tb_nmi  out  1  NMI pulse.
- fire_cnt  out  16  events fired; saturates at 16'hFFFF.
- timeout_err  out  1  sticky: a level interrupt hit MAX_HOLD without an ack.

## Operation
- LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1).
  - Shifts every cycle out of reset, regardless of state.
- FSM states: IDLE, GAP, HOLD, PULSE.
- IDLE: all interrupt outputs are 0.
  - Moves to GAP when cfg_ena=1 and tb_stop=0.
- GAP entry loads gap_cnt = MIN_GAP + (lfsr[15:8] & GAP_MASK), using the LFSR value in the entry cycle. The width is enough that the sum cannot overflow.
- GAP counting:
  - gap_cnt decrements in every GAP cycle when cfg_wfi=0.
  - When cfg_wfi=1, it decrements only in cycles where core_wfi=1.
- GAP exit: on the counting cycle where gap_cnt==1, select a source from sel=lfsr[2:0]:
  - 0,1 → tmr; 2,3 → sft; 4,5 → plic; 6 → nmi; 7 → dbg.
- If the selected source is unmasked:
  - tmr/sft/plic/dbg → HOLD.
  - nmi → PULSE.
  - fire_cnt increments.
- If the selected source is masked: reload gap_cnt and stay in GAP. fire_cnt does not increment.
- HOLD:
  - The selected output is high and hold_cnt counts the cycles it has been high.
  - Exit to GAP when irq_ack for the active source is 1.
  - Exit to GAP when hold_cnt reaches MAX_HOLD; this sets timeout_err.
  - Ack of a non-active source is ignored. irq_ack is ignored outside HOLD.
- PULSE: tb_nmi is high for exactly NMI_PULSE cycles, then GAP. No ack is used.
- At most one interrupt output is high in any cycle.
- Abort: cfg_ena=0 or tb_stop=1 in any state → IDLE next cycle, outputs 0.
  - timeout_err and fire_cnt are retained.

## Timing
- All outputs are registered.
- Reset values: all interrupt outputs 0, fire_cnt=0, timeout_err=0, state IDLE, lfsr=SEED.
- Reset mid-event: outputs drop to 0 in the cycle after tb_rst is sampled high.
- IDLE→GAP takes 1 cycle after cfg_ena is sampled high.
- With cfg_wfi=0, GAP lasts exactly gap_cnt cycles. The interrupt output rises in the first HOLD/PULSE cycle.
- Ack latency: ack sampled in cycle N → output low in cycle N+1, and state GAP in cycle N+1.
- Minimum high time is 1 cycle; an ack is honoured in the first HOLD cycle.
- Timeout: the output stays high for exactly MAX_HOLD cycles. timeout_err rises in the same cycle the output falls.
- Ack and timeout in the same cycle: ack wins, timeout_err is not set.
- Abort and ack in the same cycle: IDLE; the ack is consumed.
- Leaving GAP for HOLD or PULSE and re-entering GAP both load a fresh gap value.

## Test plan
- Basic fire: GAP_MASK=0, MIN_GAP=16, SEED=1, src_mask=5'h1F, cfg_ena rises at cycle 0, irq_ack tied to its level output delayed 3 cycles.
  - First output rises at cycle 17.
  - It stays high 4 cycles.
  - fire_cnt=1.
- Timeout: MAX_HOLD=8, irq_ack=0, src_mask=5'h01 (tmr only).
  - tb_tmr_irq is high exactly 8 cycles, then falls.
  - timeout_err=1 in the same cycle.
  - The next GAP follows.
  - Repeat with ack at hold cycle 8: timeout_err stays 0.
- NMI only: src_mask=5'h08, NMI_PULSE=4, 64 events.
  - Every tb_nmi pulse is exactly 4 cycles.
  - No level output ever goes high.
  - fire_cnt=64.
- WFI gating: cfg_wfi=1, GAP_MASK=0, MIN_GAP=10, core_wfi high 5 cycles, low 20, high 5.
  - The interrupt rises only in the cycle after the 10th core_wfi=1 cycle.
- Abort/reset: tb_stop=1 during HOLD, then tb_rst=1 during a later PULSE.
  - Each output is 0 in the next cycle; state is IDLE.
  - After reset: fire_cnt=0 and lfsr=SEED.
  - Two runs with the same SEED give identical output traces.
- Exclusivity and masking: run 10,000 cycles with random acks and src_mask=5'h00.
  - No output is ever high and fire_cnt=0.
  - With src_mask=5'h1F, the onehot0 check on all outputs holds every cycle.
